if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 17 +
 rtl/next_pc_sel.sv | 27 ++
 rtl/if_stage.sv | 154 +++++++++++++++
 tb/tb_if_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Imported by the fetch top and its next-PC selector.
package if_stage_pkg;

    typedef logic [31:0] pc_t;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_DROP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam pc_t         RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Redirect target select (JR > JMP > branch) and sequential PC+4.
// Purely combinational; the low two target bits are always cleared.
module next_pc_sel
    import if_stage_pkg::*;
(
    input  logic       i_jr,
    input  logic       i_jmp,
    input  pc_t        i_jaddr,
    input  pc_t        i_branch_target,
    input  logic [3:0] i_pc4_hi,
    input  pc_t        i_pc,
    output pc_t        o_target,
    output pc_t        o_seq
);

    always_comb begin
        o_target = i_branch_target & 32'hFFFF_FFFC;
        if (i_jr) begin
            o_target = i_jaddr & 32'hFFFF_FFFC;
        end else if (i_jmp) begin
            o_target = {i_pc4_hi, i_jaddr[25:0], 2'b00};
        end
    end

    assign o_seq = i_pc + 32'd4;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem handshake with wait states,
// decode-resolved redirects, stalls, halt, and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter pc_t         RESET_PC = if_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_WORD = if_stage_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        CLR_n,
    input  logic        Stall,
    input  logic        Branch_taken,
    input  logic [31:0] branch_target,
    input  logic        JMP,
    input  logic        JR,
    input  logic [31:0] jaddr,
    input  logic        HALT,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] PC_4,
    output logic        if_valid,
    output logic [31:0] PC,
    output logic        halted
);

    state_t      r_state;
    pc_t         r_pc;
    pc_t         r_pc4;
    pc_t         r_redir_pc;
    logic [31:0] r_ir;
    logic [31:0] r_hold;
    logic        r_valid;
    logic        r_halt_flag;

    logic        w_redirect;
    pc_t         w_target;
    pc_t         w_seq;

    assign w_redirect = (Branch_taken | JMP | JR) & ~Stall;

    next_pc_sel u_sel (
        .i_jr            (JR),
        .i_jmp           (JMP),
        .i_jaddr         (jaddr),
        .i_branch_target (branch_target),
        .i_pc4_hi        (r_pc4[31:28]),
        .i_pc            (r_pc),
        .o_target        (w_target),
        .o_seq           (w_seq)
    );

    always_ff @(posedge clk) begin
        if (!CLR_n) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_pc4       <= '0;
            r_redir_pc  <= '0;
            r_ir        <= NOP_WORD;
            r_hold      <= NOP_WORD;
            r_valid     <= 1'b0;
            r_halt_flag <= 1'b0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (HALT) begin
                        r_ir    <= NOP_WORD;
                        r_valid <= 1'b0;
                        if (imem_ready) begin
                            r_state <= S_HALTED;
                        end else begin
                            r_halt_flag <= 1'b1;
                            r_state     <= S_DROP;
                        end
                    end else if (imem_ready && w_redirect) begin
                        r_ir    <= NOP_WORD;
                        r_valid <= 1'b0;
                        r_pc    <= w_target;
                    end else if (imem_ready && Stall) begin
                        r_hold  <= imem_rdata;
                        r_state <= S_HOLD;
                    end else if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_pc4   <= w_seq;
                        r_valid <= 1'b1;
                        r_pc    <= w_seq;
                    end else if (w_redirect) begin
                        r_redir_pc <= w_target;
                        r_ir       <= NOP_WORD;
                        r_valid    <= 1'b0;
                        r_state    <= S_DROP;
                    end else if (!Stall) begin
                        r_ir    <= NOP_WORD;
                        r_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (HALT) begin
                        r_ir    <= NOP_WORD;
                        r_valid <= 1'b0;
                        r_state <= S_HALTED;
                    end else if (!Stall) begin
                        if (w_redirect) begin
                            r_ir    <= NOP_WORD;
                            r_valid <= 1'b0;
                            r_pc    <= w_target;
                        end else begin
                            r_ir    <= r_hold;
                            r_pc4   <= w_seq;
                            r_valid <= 1'b1;
                            r_pc    <= w_seq;
                        end
                        r_state <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (HALT || !Stall) begin
                        r_ir    <= NOP_WORD;
                        r_valid <= 1'b0;
                    end
                    // the late response is thrown away; latest redirect wins
                    if (imem_ready) begin
                        if (r_halt_flag || HALT) begin
                            r_state <= S_HALTED;
                        end else begin
                            r_pc    <= w_redirect ? w_target : r_redir_pc;
                            r_state <= S_FETCH;
                        end
                    end else if (HALT) begin
                        r_halt_flag <= 1'b1;
                    end else if (w_redirect) begin
                        r_redir_pc <= w_target;
                    end
                end
                S_HALTED: begin
                    r_ir    <= NOP_WORD;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = CLR_n &
                       ((r_state == S_FETCH) || (r_state == S_DROP));
    assign imem_addr = r_pc;
    assign IR        = r_ir;
    assign PC_4      = r_pc4;
    assign if_valid  = r_valid;
    assign PC        = r_pc;
    assign halted    = (r_state == S_HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Directed cycle-by-cycle vectors for the fetch stage: streaming,
// wait states, stall/HOLD, redirects, DROP, halt, reset and wrap.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        CLR_n = 1'b0;
    logic        Stall = 1'b0;
    logic        Branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        JMP = 1'b0;
    logic        JR = 1'b0;
    logic [31:0] jaddr = '0;
    logic        HALT = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] IR;
    logic [31:0] PC_4;
    logic        if_valid;
    logic [31:0] PC;
    logic        halted;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // memory content is a fixed function of the address
    assign imem_rdata = imem_addr ^ 32'hC0DE_0000;

    if_stage dut (
        .clk           (clk),
        .CLR_n         (CLR_n),
        .Stall         (Stall),
        .Branch_taken  (Branch_taken),
        .branch_target (branch_target),
        .JMP           (JMP),
        .JR            (JR),
        .jaddr         (jaddr),
        .HALT          (HALT),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IR            (IR),
        .PC_4          (PC_4),
        .if_valid      (if_valid),
        .PC            (PC),
        .halted        (halted)
    );

    typedef struct {
        logic        clr, stall, br, jmp, jr, halt, rdy;
        logic [31:0] btgt, jad;
        logic        ereq;
        logic [31:0] eaddr, eir, epc4;
        logic        ev;
        logic [31:0] epc;
        logic        eh;
    } vec_t;

    function automatic logic [31:0] wd(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t v(
        input logic clr, stall, br, jmp, jr, halt, rdy,
        input logic [31:0] btgt, jad,
        input logic ereq, input logic [31:0] eaddr,
        input logic [31:0] eir, epc4, input logic ev,
        input logic [31:0] epc, input logic eh);
        vec_t t;
        t.clr = clr; t.stall = stall; t.br = br;
        t.jmp = jmp; t.jr = jr; t.halt = halt;
        t.rdy = rdy; t.btgt = btgt; t.jad = jad;
        t.ereq = ereq; t.eaddr = eaddr;
        t.eir = eir; t.epc4 = epc4; t.ev = ev;
        t.epc = epc; t.eh = eh;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h",
                     nm, idx, got, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        CLR_n = t.clr; Stall = t.stall;
        Branch_taken = t.br; branch_target = t.btgt;
        JMP = t.jmp; JR = t.jr; jaddr = t.jad;
        HALT = t.halt; imem_ready = t.rdy;
        #1;
        chk("req", idx, {31'b0, imem_req}, {31'b0, t.ereq});
        if (t.ereq) chk("addr", idx, imem_addr, t.eaddr);
        @(posedge clk);
        #1;
        chk("ir", idx, IR, t.eir);
        chk("pc4", idx, PC_4, t.epc4);
        chk("valid", idx, {31'b0, if_valid}, {31'b0, t.ev});
        chk("pc", idx, PC, t.epc);
        chk("halted", idx, {31'b0, halted}, {31'b0, t.eh});
    endtask

    vec_t tbl[$];

    initial begin
        // clr stl br jmp jr hlt rdy btgt jaddr | req addr ir pc4 v pc h
        tbl.push_back(v(0,0,0,0,0,0,0, 0, 0, 0, 0,
                        0, 0, 0, 32'h3000, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h3000,
                        wd(32'h3000), 32'h3004, 1, 32'h3004, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h3004,
                        wd(32'h3004), 32'h3008, 1, 32'h3008, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h3008,
                        wd(32'h3008), 32'h300C, 1, 32'h300C, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1,0,0,0,0,0,0, 0, 0, 1, 32'h300C,
                            0, 32'h300C, 0, 32'h300C, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h300C,
                        wd(32'h300C), 32'h3010, 1, 32'h3010, 0));
        tbl.push_back(v(1,1,0,0,0,0,1, 0, 0, 1, 32'h3010,
                        wd(32'h300C), 32'h3010, 1, 32'h3010, 0));
        tbl.push_back(v(1,1,0,0,0,0,1, 0, 0, 0, 0,
                        wd(32'h300C), 32'h3010, 1, 32'h3010, 0));
        tbl.push_back(v(1,0,0,0,0,0,0, 0, 0, 0, 0,
                        wd(32'h3010), 32'h3014, 1, 32'h3014, 0));
        tbl.push_back(v(1,0,0,0,1,0,0, 0, 32'h4003, 1, 32'h3014,
                        0, 32'h3014, 0, 32'h3014, 0));
        tbl.push_back(v(1,0,0,0,0,0,0, 0, 0, 1, 32'h3014,
                        0, 32'h3014, 0, 32'h3014, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h3014,
                        0, 32'h3014, 0, 32'h4000, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h4000,
                        wd(32'h4000), 32'h4004, 1, 32'h4004, 0));
        tbl.push_back(v(1,0,1,1,0,0,1, 32'h5000, 32'h100, 1, 32'h4004,
                        0, 32'h4004, 0, 32'h0400, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h0400,
                        wd(32'h0400), 32'h0404, 1, 32'h0404, 0));
        tbl.push_back(v(1,0,1,0,0,0,1, 32'h6006, 0, 1, 32'h0404,
                        0, 32'h0404, 0, 32'h6004, 0));
        tbl.push_back(v(1,1,0,0,1,0,0, 0, 32'h8000, 1, 32'h6004,
                        0, 32'h0404, 0, 32'h6004, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h6004,
                        wd(32'h6004), 32'h6008, 1, 32'h6008, 0));
        tbl.push_back(v(1,0,0,0,0,1,0, 0, 0, 1, 32'h6008,
                        0, 32'h6008, 0, 32'h6008, 0));
        tbl.push_back(v(1,0,0,0,0,0,0, 0, 0, 1, 32'h6008,
                        0, 32'h6008, 0, 32'h6008, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h6008,
                        0, 32'h6008, 0, 32'h6008, 1));
        tbl.push_back(v(1,0,0,0,1,0,1, 0, 32'h9000, 0, 0,
                        0, 32'h6008, 0, 32'h6008, 1));
        tbl.push_back(v(0,0,0,0,0,0,1, 0, 0, 0, 0,
                        0, 0, 0, 32'h3000, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h3000,
                        wd(32'h3000), 32'h3004, 1, 32'h3004, 0));
        tbl.push_back(v(1,0,0,0,1,0,1, 0, 32'hFFFF_FFFF, 1, 32'h3004,
                        0, 32'h3004, 0, 32'hFFFF_FFFC, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'hFFFF_FFFC,
                        wd(32'hFFFF_FFFC), 0, 1, 0, 0));
        tbl.push_back(v(1,0,0,0,0,0,0, 0, 0, 1, 0,
                        0, 0, 0, 0, 0));
        tbl.push_back(v(0,0,0,0,0,0,1, 0, 0, 0, 0,
                        0, 0, 0, 32'h3000, 0));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h3000,
                        wd(32'h3000), 32'h3004, 1, 32'h3004, 0));
        tbl.push_back(v(1,0,0,0,0,1,1, 0, 0, 1, 32'h3004,
                        0, 32'h3004, 0, 32'h3004, 1));
        tbl.push_back(v(1,0,0,0,0,0,1, 0, 0, 0, 0,
                        0, 32'h3004, 0, 32'h3004, 1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // DROP latest-wins, HOLD with redirect, HALT from HOLD
        apply(v(0,0,0,0,0,0,0, 0, 0, 0, 0,
                0, 0, 0, 32'h3000, 0), 100);
        apply(v(1,0,0,0,1,0,0, 0, 32'h5000, 1, 32'h3000,
                0, 0, 0, 32'h3000, 0), 101);
        apply(v(1,0,1,0,0,0,0, 32'h6000, 0, 1, 32'h3000,
                0, 0, 0, 32'h3000, 0), 102);
        apply(v(1,0,0,0,0,0,1, 0, 0, 1, 32'h3000,
                0, 0, 0, 32'h6000, 0), 103);
        apply(v(1,1,0,0,0,0,1, 0, 0, 1, 32'h6000,
                0, 0, 0, 32'h6000, 0), 104);
        apply(v(1,0,1,0,0,0,0, 32'h7000, 0, 0, 0,
                0, 0, 0, 32'h7000, 0), 105);
        apply(v(1,1,0,0,0,0,1, 0, 0, 1, 32'h7000,
                0, 0, 0, 32'h7000, 0), 106);
        apply(v(1,1,0,0,0,1,0, 0, 0, 0, 0,
                0, 0, 0, 32'h7000, 1), 107);
        apply(v(1,0,0,0,0,0,1, 0, 0, 0, 0,
                0, 0, 0, 32'h7000, 1), 108);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
